image_raster_reader: RTL and testbench

//  Downstream consumer of the image memory: on Start, sweeps every pixel of the Width x Height

---
 rtl/image_raster_reader_pkg.sv | 25 ++
 rtl/image_raster_reader_pixel_fifo.sv | 52 +++++
 rtl/image_raster_reader.sv | 144 ++++++++++++++
 tb/tb_image_raster_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/image_raster_reader_pkg.sv
// Shared types for the raster reader: coordinate widths, FSM states, and the pixel record
// that travels from the memory read stage through the output FIFO.
package image_pkg;

    localparam int XBits        = 9;
    localparam int YBits        = 8;
    // Colour field is sized for the widest supported pixel; narrower images zero-extend.
    localparam int MaxColorBits = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [MaxColorBits-1:0] data;
        logic [XBits-1:0]        x;
        logic [YBits-1:0]        y;
        logic                    line_end;
        logic                    last;
    } pixel_t;

endpackage

// File: rtl/image_raster_reader_pixel_fifo.sv
// First-word-fall-through FIFO of pixel records. The head entry is visible whenever
// count is non-zero. Push and pop in the same cycle leave count unchanged.
module pixel_fifo
    import image_pkg::*;
#(
    parameter int Depth   = 4,
    localparam int PtrBits = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pixel_t           push_data,
    input  logic             pop,
    output pixel_t           head,
    output logic [PtrBits:0] count
);

    pixel_t             mem [Depth];
    logic [PtrBits-1:0] wr_ptr;
    logic [PtrBits-1:0] rd_ptr;

    // Storage array: written on push, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; Depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/image_raster_reader.sv
// Raster-order image reader. Issues one memory address per cycle while output credits
// remain, tracks each read through a two-stage in-flight pipeline (issue, read), and
// pushes the returned pixel with its coordinates into an output FIFO that feeds a
// valid/ready stream.
//
// Handshake: a pixel transfers on a rising edge where PixelValid and PixelReady are both 1.
// PixelValid never drops and the pixel fields never change until that transfer happens.
module image_raster_reader
    import image_pkg::*;
#(
    parameter int Width     = 5,
    parameter int Height    = 10,
    parameter int ColorBits = 3,
    parameter int FifoDepth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    output logic [XBits-1:0]     XRead,
    output logic [YBits-1:0]     YRead,
    input  logic [ColorBits-1:0] ReadValue,
    output logic                 PixelValid,
    input  logic                 PixelReady,
    output logic [ColorBits-1:0] PixelData,
    output logic [XBits-1:0]     PixelX,
    output logic [YBits-1:0]     PixelY,
    output logic                 LineEnd,
    output logic                 PixelLast,
    output state_t               State
);

    localparam int                CntBits = $clog2(FifoDepth) + 1;
    localparam logic [XBits-1:0]  XLast   = XBits'(Width - 1);
    localparam logic [YBits-1:0]  YLast   = YBits'(Height - 1);

    state_t             state;
    logic               iss_v, iss_le, iss_last;
    logic               rd_v, rd_le, rd_last;
    logic [XBits-1:0]   rd_x;
    logic [YBits-1:0]   rd_y;
    logic [CntBits-1:0] fifo_count;
    logic [CntBits:0]   in_use;
    logic               issue, push, pop;
    logic [XBits-1:0]   next_x;
    logic [YBits-1:0]   next_y;
    logic               next_le, next_last;
    pixel_t             push_pix, head;
    logic               unused_data;

    // Credit check and next raster address; Start in IDLE always restarts at (0,0).
    always_comb begin
        in_use = (CntBits+1)'(fifo_count) + (CntBits+1)'(iss_v) + (CntBits+1)'(rd_v);
        issue  = (state == IDLE && Start) ||
                 (state == SCAN && in_use < (CntBits+1)'(FifoDepth));
        next_x = '0;
        next_y = '0;
        if (state != IDLE) begin
            if (XRead == XLast) begin
                next_x = '0;
                next_y = YRead + 1'b1;
            end else begin
                next_x = XRead + 1'b1;
                next_y = YRead;
            end
        end
        next_le   = (next_x == XLast);
        next_last = next_le && (next_y == YLast);
    end

    // FSM, address registers and the issue/read in-flight stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            XRead    <= '0;
            YRead    <= '0;
            iss_v    <= 1'b0;
            iss_le   <= 1'b0;
            iss_last <= 1'b0;
            rd_v     <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_le    <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            iss_v <= issue;
            if (issue) begin
                XRead    <= next_x;
                YRead    <= next_y;
                iss_le   <= next_le;
                iss_last <= next_last;
            end
            rd_v    <= iss_v;
            rd_x    <= XRead;
            rd_y    <= YRead;
            rd_le   <= iss_le;
            rd_last <= iss_last;
            case (state)
                IDLE:  if (Start) state <= next_last ? DRAIN : SCAN;
                SCAN:  if (issue && next_last) state <= DRAIN;
                DRAIN: if (pop && fifo_count == CntBits'(1) && !rd_v && !iss_v) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory data is valid the cycle after the read stage; capture it with its tags.
    always_comb begin
        push_pix          = '0;
        push_pix.data     = MaxColorBits'(ReadValue);
        push_pix.x        = rd_x;
        push_pix.y        = rd_y;
        push_pix.line_end = rd_le;
        push_pix.last     = rd_last;
    end

    assign push = rd_v;
    assign pop  = PixelValid && PixelReady;

    pixel_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_pix),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign PixelValid  = (fifo_count != '0);
    assign PixelData   = PixelValid ? head.data[ColorBits-1:0] : '0;
    assign PixelX      = PixelValid ? head.x : '0;
    assign PixelY      = PixelValid ? head.y : '0;
    assign LineEnd     = PixelValid && head.line_end;
    assign PixelLast   = PixelValid && head.last;
    assign unused_data = ^head.data;

    assign Busy  = (state != IDLE);
    assign Done  = (state == DONE);
    assign State = state;

endmodule

// File: tb/tb_image_raster_reader.sv
// Bench for image_raster_reader: a 5x10 instance with a registered memory model holding
// (x+y)%8, plus a 1x1 instance for the single-pixel frame.
module tb_image_raster_reader;
    import image_pkg::*;

    localparam int W = 5;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       busy, done, pixel_valid, line_end, pixel_last;
    logic [8:0] x_read, pixel_x;
    logic [7:0] y_read, pixel_y;
    logic [2:0] read_value = 3'd0;
    logic [2:0] pixel_data;
    state_t     state_dbg;

    logic       start1 = 1'b0;
    logic       ready1 = 1'b1;
    logic       busy1, done1, valid1, le1, last1;
    logic [8:0] x_read1, px1;
    logic [7:0] y_read1, py1;
    logic [2:0] read_value1 = 3'd0;
    logic [2:0] pd1;
    state_t     state_dbg1;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          xfer_count = 0;
    int          first_pix_cyc = 0;
    int          last_pix_cyc = 0;
    int          max_cnt = 0;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: one-cycle registered read
    always @(posedge clk) read_value <= 3'((32'(x_read) + 32'(y_read)) % 8);
    always @(posedge clk) read_value1 <= (x_read1 == 9'd0 && y_read1 == 8'd0) ? 3'd5 : 3'd0;

    image_raster_reader #(.Width(W), .Height(H), .ColorBits(3), .FifoDepth(4)) dut (
        .clk(clk), .rst(rst), .Start(start), .Busy(busy), .Done(done),
        .XRead(x_read), .YRead(y_read), .ReadValue(read_value),
        .PixelValid(pixel_valid), .PixelReady(ready), .PixelData(pixel_data),
        .PixelX(pixel_x), .PixelY(pixel_y), .LineEnd(line_end), .PixelLast(pixel_last),
        .State(state_dbg)
    );

    image_raster_reader #(.Width(1), .Height(1), .ColorBits(3), .FifoDepth(4)) dut1 (
        .clk(clk), .rst(rst), .Start(start1), .Busy(busy1), .Done(done1),
        .XRead(x_read1), .YRead(y_read1), .ReadValue(read_value1),
        .PixelValid(valid1), .PixelReady(ready1), .PixelData(pd1),
        .PixelX(px1), .PixelY(py1), .LineEnd(le1), .PixelLast(last1),
        .State(state_dbg1)
    );

    wire [31:0] got_word = {10'd0, pixel_data, pixel_x, pixel_y, line_end, pixel_last};
    wire [31:0] got1     = {10'd0, pd1, px1, py1, le1, last1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix_word(input int x, input int y);
        logic le, last;
        le   = (x == W - 1);
        last = le && (y == H - 1);
        return {10'd0, 3'((x + y) % 8), 9'(x), 8'(y), le, last};
    endfunction

    // Scoreboard: every transfer is compared against the front of the expected queue
    always @(negedge clk) begin
        if (!rst && pixel_valid && ready) begin
            check("q_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("pixel", got_word, exp_q.pop_front());
            if (xfer_count == 0) first_pix_cyc = cyc;
            if (pixel_last) last_pix_cyc = cyc;
            xfer_count++;
        end
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end

    task automatic start_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back(pix_word(x, y));
        xfer_count = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("lat0_busy", 32'(busy), 32'd1);
        check("lat0_addr", 32'({x_read, y_read}), 32'd0);
        check("lat0_valid", 32'(pixel_valid), 32'd0);
        @(posedge clk); #1;
        check("lat1_valid", 32'(pixel_valid), 32'd0);
        @(posedge clk); #1;
        check("lat2_valid", 32'(pixel_valid), 32'd1);
    endtask

    task automatic run_until_done(input bit rand_ready);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(posedge clk); #1;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_lat", 32'(cyc), 32'(last_pix_cyc + 1));
        check("frame_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_after_done();
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_addr", 32'({x_read, y_read}), 32'd0);
        check("rst_out", got_word, 32'd0);

        // 1: full frame, no backpressure
        ready = 1'b1;
        start_frame();
        run_until_done(1'b0);
        check("b2b_span", 32'(last_pix_cyc - first_pix_cyc), 32'd49);
        check("xfer_total", 32'(xfer_count), 32'd50);
        idle_after_done();

        // 2: 10-cycle stall mid-row with pixel (2,1) at the head
        start_frame();
        for (int n = 0; n < 200 && xfer_count < 7; n++) begin
            @(posedge clk); #1;
        end
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(pixel_valid), 32'd1);
            if (exp_q.size() != 0) check("stall_head", got_word, exp_q[0]);
            if (i >= 1) check("stall_xread", 32'({x_read, y_read}), 32'({9'd0, 8'd2}));
        end
        check("stall_fill", 32'(dut.u_fifo.count), 32'd4);
        @(posedge clk); #1 ready = 1'b1;
        run_until_done(1'b0);
        idle_after_done();

        // 3: random backpressure
        max_cnt = 0;
        start_frame();
        run_until_done(1'b1);
        ready = 1'b1;
        check("fifo_max", 32'(max_cnt <= 4), 32'd1);
        idle_after_done();

        // 4: Start in SCAN and DONE ignored, then a fresh frame
        start_frame();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_until_done(1'b0);
        check("xfer_once", 32'(xfer_count), 32'd50);
        start = 1'b1;
        idle_after_done();
        start = 1'b0;
        @(posedge clk); #1;
        check("done_start_ign", 32'(busy), 32'd0);
        start_frame();
        run_until_done(1'b0);
        idle_after_done();

        // 5: reset mid-frame, then a full frame
        start_frame();
        for (int n = 0; n < 200 && xfer_count < 16; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_valid", 32'(pixel_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_addr", 32'({x_read, y_read}), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        start_frame();
        run_until_done(1'b0);
        check("post_rst_total", 32'(xfer_count), 32'd50);
        idle_after_done();

        // 6: single-pixel 1x1 frame
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        check("p1_busy", 32'(busy1), 32'd1);
        check("p1_lat0", 32'(valid1), 32'd0);
        @(posedge clk); #1;
        check("p1_lat1", 32'(valid1), 32'd0);
        @(posedge clk); #1;
        check("p1_valid", 32'(valid1), 32'd1);
        check("p1_pixel", got1, {10'd0, 3'd5, 9'd0, 8'd0, 1'b1, 1'b1});
        @(posedge clk); #1;
        check("p1_done", 32'(done1), 32'd1);
        check("p1_empty", 32'(valid1), 32'd0);
        @(posedge clk); #1;
        check("p1_done_end", 32'(done1), 32'd0);
        check("p1_idle", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
